// File: rtl/reg_file_if.sv
// Register-file access bundle: two read ports, one masked write port and a claim port.
interface reg_file_if #(
  parameter int unsigned data_size = 16,
  parameter int unsigned reg_count = 8
);
  localparam int unsigned addr_size = $clog2(reg_count);

  logic [addr_size-1:0]   raddr_a;
  logic [data_size-1:0]   rdata_a;
  logic                   busy_a;
  logic [addr_size-1:0]   raddr_b;
  logic [data_size-1:0]   rdata_b;
  logic                   busy_b;
  logic                   wenable;
  logic [addr_size-1:0]   waddr;
  logic [data_size-1:0]   wdata;
  logic [data_size/8-1:0] wmask;
  logic                   claim;
  logic [addr_size-1:0]   claim_addr;

  modport master (
    output raddr_a, raddr_b, wenable, waddr, wdata, wmask, claim, claim_addr,
    input  rdata_a, busy_a, rdata_b, busy_b
  );

  modport slave (
    input  raddr_a, raddr_b, wenable, waddr, wdata, wmask, claim, claim_addr,
    output rdata_a, busy_a, rdata_b, busy_b
  );
endinterface

// File: rtl/reg_file.sv
// Architectural register file: byte-masked write, write-to-read bypass on both read
// ports, and a per-register busy scoreboard set by claims and cleared by writeback.
module reg_file #(
  parameter int unsigned data_size = 16,
  parameter int unsigned reg_count = 8,
  parameter int unsigned zero_reg  = 1
) (
  input  logic       clk,
  input  logic       rstn,
  reg_file_if.slave  bus
);
  localparam int unsigned addr_size = $clog2(reg_count);
  localparam int unsigned lanes     = data_size / 8;

  logic [data_size-1:0] r_mem [reg_count];
  logic [reg_count-1:0] r_busy;

  logic                 w_wr_ok;
  logic                 w_claim_ok;
  logic [addr_size-1:0] w_raddr [2];
  logic [data_size-1:0] w_rdata [2];
  logic                 w_busy  [2];

  // Writable/claimable: inside the array and not the hardwired zero register.
  function automatic logic addr_ok(input logic [addr_size-1:0] a);
    return (32'(a) < reg_count) && !((zero_reg != 0) && (a == '0));
  endfunction

  function automatic logic [data_size-1:0] merge(input logic [data_size-1:0] old_v,
                                                 input logic [data_size-1:0] new_v,
                                                 input logic [lanes-1:0]     m);
    logic [data_size-1:0] res;
    res = old_v;
    for (int unsigned i = 0; i < lanes; i++) begin
      if (m[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign w_wr_ok    = bus.wenable && addr_ok(bus.waddr);
  assign w_claim_ok = bus.claim && addr_ok(bus.claim_addr);

  // Storage and scoreboard; a claim beats a completing write to the same register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned r = 0; r < reg_count; r++) r_mem[r] <= '0;
      r_busy <= '0;
    end else begin
      for (int unsigned r = 0; r < reg_count; r++) begin
        if (w_wr_ok && (bus.waddr == addr_size'(r)))
          r_mem[r] <= merge(r_mem[r], bus.wdata, bus.wmask);
        if (w_claim_ok && (bus.claim_addr == addr_size'(r)))
          r_busy[r] <= 1'b1;
        else if (w_wr_ok && (bus.waddr == addr_size'(r)))
          r_busy[r] <= 1'b0;
      end
    end
  end

  assign w_raddr[0] = bus.raddr_a;
  assign w_raddr[1] = bus.raddr_b;

  // Read ports: stored value, overridden by a same-cycle write; held at 0 in reset.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      w_rdata[p] = '0;
      w_busy[p]  = 1'b0;
      for (int unsigned r = 0; r < reg_count; r++) begin
        if (w_raddr[p] == addr_size'(r)) begin
          w_rdata[p] = r_mem[r];
          w_busy[p]  = r_busy[r];
        end
      end
      if ((zero_reg != 0) && (w_raddr[p] == '0)) begin
        w_rdata[p] = '0;
        w_busy[p]  = 1'b0;
      end
      if (w_wr_ok && (bus.waddr == w_raddr[p])) begin
        w_rdata[p] = merge(w_rdata[p], bus.wdata, bus.wmask);
        if (!(w_claim_ok && (bus.claim_addr == w_raddr[p]))) w_busy[p] = 1'b0;
      end
      if (!rstn) begin
        w_rdata[p] = '0;
        w_busy[p]  = 1'b0;
      end
    end
  end

  assign bus.rdata_a = w_rdata[0];
  assign bus.busy_a  = w_busy[0];
  assign bus.rdata_b = w_rdata[1];
  assign bus.busy_b  = w_busy[1];
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: three configurations (default, zero_reg=0, reg_count=6) share one
// stimulus stream and are checked against directed vectors and a behavioural model.
module tb_reg_file;
  logic clk;
  logic rstn;
  logic wen, claim;
  logic [2:0] waddr, caddr, ra, rb;
  logic [15:0] wdata;
  logic [1:0] wmask;

  int tests = 0;
  int fails = 0;

  reg_file_if #(.data_size(16), .reg_count(8)) if0 ();
  reg_file_if #(.data_size(16), .reg_count(8)) if1 ();
  reg_file_if #(.data_size(16), .reg_count(6)) if2 ();

  assign {if0.raddr_a, if0.raddr_b, if0.wenable, if0.waddr, if0.wdata, if0.wmask, if0.claim, if0.claim_addr}
       = {ra, rb, wen, waddr, wdata, wmask, claim, caddr};
  assign {if1.raddr_a, if1.raddr_b, if1.wenable, if1.waddr, if1.wdata, if1.wmask, if1.claim, if1.claim_addr}
       = {ra, rb, wen, waddr, wdata, wmask, claim, caddr};
  assign {if2.raddr_a, if2.raddr_b, if2.wenable, if2.waddr, if2.wdata, if2.wmask, if2.claim, if2.claim_addr}
       = {ra, rb, wen, waddr, wdata, wmask, claim, caddr};

  reg_file #(.data_size(16), .reg_count(8), .zero_reg(1)) dut0 (.clk(clk), .rstn(rstn), .bus(if0));
  reg_file #(.data_size(16), .reg_count(8), .zero_reg(0)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
  reg_file #(.data_size(16), .reg_count(6), .zero_reg(1)) dut2 (.clk(clk), .rstn(rstn), .bus(if2));

  logic [15:0] rd_a [3];
  logic [15:0] rd_b [3];
  logic        bz_a [3];
  logic        bz_b [3];
  assign rd_a[0] = if0.rdata_a; assign rd_b[0] = if0.rdata_b;
  assign bz_a[0] = if0.busy_a;  assign bz_b[0] = if0.busy_b;
  assign rd_a[1] = if1.rdata_a; assign rd_b[1] = if1.rdata_b;
  assign bz_a[1] = if1.busy_a;  assign bz_b[1] = if1.busy_b;
  assign rd_a[2] = if2.rdata_a; assign rd_b[2] = if2.rdata_b;
  assign bz_a[2] = if2.busy_a;  assign bz_b[2] = if2.busy_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain arrays of register contents and pending flags per config.
  int          rc [3] = '{8, 8, 6};
  int          zr [3] = '{1, 0, 1};
  logic [15:0] m_mem  [3][8];
  logic        m_busy [3][8];

  function automatic logic valid_addr(int d, logic [2:0] a);
    return (int'(a) < rc[d]) && !(zr[d] != 0 && a == 3'd0);
  endfunction

  function automatic logic [15:0] lane_mask(logic [1:0] m);
    return {{8{m[1]}}, {8{m[0]}}};
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 8; r++) begin
        m_mem[d][r]  = 16'h0;
        m_busy[d][r] = 1'b0;
      end
  endtask

  task automatic model_step();
    logic wr_ok, c_ok;
    if (!rstn) return;
    for (int d = 0; d < 3; d++) begin
      wr_ok = wen && valid_addr(d, waddr);
      c_ok  = claim && valid_addr(d, caddr);
      if (wr_ok) begin
        m_mem[d][waddr] = (m_mem[d][waddr] & ~lane_mask(wmask)) | (wdata & lane_mask(wmask));
        if (!(c_ok && caddr == waddr)) m_busy[d][waddr] = 1'b0;
      end
      if (c_ok) m_busy[d][caddr] = 1'b1;
    end
  endtask

  task automatic model_read(int d, logic [2:0] a, output logic [15:0] dat, output logic b);
    dat = 16'h0;
    b   = 1'b0;
    if (!rstn || !valid_addr(d, a)) return;
    dat = m_mem[d][a];
    b   = m_busy[d][a];
    if (wen && waddr == a) begin
      dat = (dat & ~lane_mask(wmask)) | (wdata & lane_mask(wmask));
      if (!(claim && caddr == a)) b = 1'b0;
    end
  endtask

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic [15:0] ed;
    logic        eb;
    for (int d = 0; d < 3; d++) begin
      model_read(d, ra, ed, eb);
      check($sformatf("%s dut%0d rdata_a@%0d", tag, d, ra), rd_a[d], ed);
      check($sformatf("%s dut%0d busy_a@%0d", tag, d, ra), 16'(bz_a[d]), 16'(eb));
      model_read(d, rb, ed, eb);
      check($sformatf("%s dut%0d rdata_b@%0d", tag, d, rb), rd_b[d], ed);
      check($sformatf("%s dut%0d busy_b@%0d", tag, d, rb), 16'(bz_b[d]), 16'(eb));
    end
  endtask

  typedef struct {
    logic        rstn;
    logic        wen;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  wmask;
    logic        claim;
    logic [2:0]  caddr;
    logic [2:0]  ra;
    logic [15:0] exp_d;
    logic        exp_b;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rs, logic we, logic [2:0] wa, logic [15:0] wd, logic [1:0] wm,
                              logic cl, logic [2:0] ca, logic [2:0] a, logic [15:0] ed, logic eb);
    vec_t v;
    v.rstn = rs; v.wen = we; v.waddr = wa; v.wdata = wd; v.wmask = wm;
    v.claim = cl; v.caddr = ca; v.ra = a; v.exp_d = ed; v.exp_b = eb;
    return v;
  endfunction

  task automatic drive(logic rs, logic we, logic [2:0] wa, logic [15:0] wd, logic [1:0] wm,
                       logic cl, logic [2:0] ca, logic [2:0] a, logic [2:0] b);
    rstn = rs; wen = we; waddr = wa; wdata = wd; wmask = wm; claim = cl; caddr = ca;
    ra = a; rb = b;
    if (!rstn) model_reset();
  endtask

  initial begin
    drive(1'b0, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0);

    // Expected values are for the default configuration (zero_reg=1, 8 entries).
    vecs[0]  = mk(0, 0, 0, 16'h0000, 2'b00, 0, 0, 3, 16'h0000, 0);
    vecs[1]  = mk(1, 1, 3, 16'hBEEF, 2'b11, 0, 0, 3, 16'hBEEF, 0);
    vecs[2]  = mk(1, 0, 0, 16'h0000, 2'b00, 1, 5, 3, 16'hBEEF, 0);
    vecs[3]  = mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 5, 16'h0000, 1);
    vecs[4]  = mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 3, 16'hBEEF, 0);
    vecs[5]  = mk(1, 1, 2, 16'h1234, 2'b11, 0, 0, 2, 16'h1234, 0);
    vecs[6]  = mk(1, 1, 2, 16'hABCD, 2'b10, 0, 0, 2, 16'hAB34, 0);
    vecs[7]  = mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 2, 16'hAB34, 0);
    vecs[8]  = mk(1, 0, 0, 16'h0000, 2'b00, 1, 4, 4, 16'h0000, 0);
    vecs[9]  = mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 4, 16'h0000, 1);
    vecs[10] = mk(1, 1, 4, 16'h0042, 2'b11, 0, 0, 4, 16'h0042, 0);
    vecs[11] = mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 4, 16'h0042, 0);
    vecs[12] = mk(1, 0, 0, 16'h0000, 2'b00, 1, 6, 6, 16'h0000, 0);
    vecs[13] = mk(1, 1, 6, 16'h0007, 2'b11, 1, 6, 6, 16'h0007, 1);
    vecs[14] = mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 6, 16'h0007, 1);
    vecs[15] = mk(1, 1, 0, 16'hFFFF, 2'b11, 1, 0, 0, 16'h0000, 0);
    vecs[16] = mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 0, 16'h0000, 0);
    vecs[17] = mk(1, 1, 7, 16'h5A5A, 2'b11, 1, 7, 7, 16'h5A5A, 0);
    vecs[18] = mk(1, 0, 0, 16'h0000, 2'b00, 0, 0, 7, 16'h5A5A, 1);

    model_reset();
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rstn, vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].wmask,
            vecs[i].claim, vecs[i].caddr, vecs[i].ra, vecs[i].ra);
      @(negedge clk);
      check($sformatf("vec%0d rdata_a", i), rd_a[0], vecs[i].exp_d);
      check($sformatf("vec%0d rdata_b", i), rd_b[0], vecs[i].exp_d);
      check($sformatf("vec%0d busy_a", i), 16'(bz_a[0]), 16'(vecs[i].exp_b));
      check($sformatf("vec%0d busy_b", i), 16'(bz_b[0]), 16'(vecs[i].exp_b));
      check_model($sformatf("vec%0d", i));
      if (i == 16) begin
        check("zero_reg=0 rdata r0", rd_a[1], 16'hFFFF);
        check("zero_reg=0 busy r0", 16'(bz_a[1]), 16'h0001);
      end
      if (i == 17 || i == 18) begin
        check($sformatf("vec%0d out-of-range rdata", i), rd_a[2], 16'h0000);
        check($sformatf("vec%0d out-of-range busy", i), 16'(bz_a[2]), 16'h0000);
      end
      @(posedge clk);
      model_step();
      #1;
    end

    // Reset between edges: loaded r3 and claimed r5 must read 0 at once and after release.
    drive(1'b1, 1'b1, 3'd3, 16'hBEEF, 2'b11, 1'b1, 3'd5, 3'd3, 3'd5);
    @(posedge clk); model_step(); #1;
    drive(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 3'd3, 3'd5);
    @(negedge clk);
    check("pre-reset r3", rd_a[0], 16'hBEEF);
    check("pre-reset r5 busy", 16'(bz_b[0]), 16'h0001);
    #2;
    drive(1'b0, 1'b1, 3'd3, 16'h1111, 2'b11, 1'b1, 3'd3, 3'd3, 3'd5);
    #1;
    check("async reset r3 data", rd_a[0], 16'h0000);
    check("async reset r5 busy", 16'(bz_b[0]), 16'h0000);
    check_model("in-reset");
    @(posedge clk); model_step(); #1;
    drive(1'b1, 1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 3'd3, 3'd5);
    @(negedge clk);
    check("post-reset r3 data", rd_a[0], 16'h0000);
    check("post-reset r3 busy", 16'(bz_a[0]), 16'h0000);
    check("post-reset r5 busy", 16'(bz_b[0]), 16'h0000);
    check_model("post-reset");
    @(posedge clk); model_step(); #1;

    // Random traffic, including occasional reset pulses.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)), 3'($urandom),
            16'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0), 3'($urandom),
            3'($urandom), 3'($urandom));
      @(negedge clk);
      check_model($sformatf("rnd%0d", n));
      @(posedge clk);
      model_step();
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
